i2c_txn_arbiter: RTL and testbench
==================================

Name: i2c_txn_arbiter

Overview:
- Round-robin arbiter and transaction sequencer that shares the single I2C master engine between NUM_REQ requesters (CPU MMIO port, sensor poller, config loader).
- Latches the winner's address, data and direction, and drives the engine's start bit (control_reg[1]).
- Tracks the engine's ready/status handshake, returns read data, a done pulse and an error code to the winner.
- Detects hung transfers and requests an engine reset.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT, 1024, clk cycles allowed in LAUNCH and in WAIT_DONE before abort (≥4).
- ABORT_LEN, 4, clk cycles m_abort is held high after a timeout.

Ports:
- clk  in  1  system clock; the engine's divided clock is derived from it.
- rst  in  1  reset, asynchronous, active-high.
- req  in  NUM_REQ  per-requester request level.
- req_addr  in  7*NUM_REQ  7-bit slave address; requester i occupies bits [7i+6:7i].
- req_wdata  in  8*NUM_REQ  write byte; requester i occupies bits [8i+7:8i].
- req_rw  in  NUM_REQ  1 = read, 0 = write.
- grant  out  NUM_REQ  one-hot owner of the engine.
- done  out  NUM_REQ  one-cycle completion pulse to the owner.
- rdata  out  8  read byte, valid while done is high.
- err_code  out  2  valid with done: 00 ok, 01 NACK, 10 launch timeout, 11 completion timeout.
- m_addr  out  7  to engine addr.
- m_wdata  out  8  to engine data_in.
- m_rw  out  1  to engine rw.
- m_start  out  1  to engine control_reg[1].
- m_ready  in  1  engine ready (high when engine is idle and out of reset).
- m_rdata  in  8  engine data_out.
- m_status  in  8  engine status register; bit2 = address NACK.
- m_abort  out  1  ORed into the engine reset at top level.

Behaviour:
- Reset values:
  - grant = 0, done = 0, rdata = 0, err_code = 0.
  - m_addr = 0, m_wdata = 0, m_rw = 0, m_start = 0, m_abort = 0.
  - Round-robin pointer ptr = 0; state = IDLE; timeout counter = 0; NACK flag = 0.
- Reset mid-transaction: all of the above apply immediately (asynchronous). No done pulse is issued for the aborted transaction.
- State IDLE:
  - If |req && m_ready: the winner is the first set req bit searching ptr, ptr+1, …, wrapping modulo NUM_REQ.
  - On that edge: grant[w] = 1; m_addr/m_wdata/m_rw are latched from slice w; go to LAUNCH.
  - Grant therefore asserts exactly 1 cycle after req is seen.
  - If m_ready is low (engine still in reset or busy from before), stay in IDLE.
- State LAUNCH:
  - m_start = 1.
  - When m_ready is sampled low: m_start = 0 on that edge, clear the counter and NACK flag, go to WAIT_DONE.
  - If the counter reaches TIMEOUT-1: err_code = 10, go to ABORT.
- State WAIT_DONE:
  - m_start = 0.
  - Sticky NACK flag is set in any cycle where m_status[2] = 1.
  - When m_ready returns high: rdata = m_rdata (forced to 0 for writes); err_code = 01 if NACK flag else 00; go to RESP.
  - If the counter reaches TIMEOUT-1: err_code = 11, go to ABORT.
- State ABORT:
  - m_abort = 1 for ABORT_LEN cycles; m_start = 0.
  - Then go to RESP with the timeout err_code.
- State RESP:
  - done[w] = 1 for exactly one cycle.
  - On the next edge: grant = 0, done = 0, ptr = (w+1) mod NUM_REQ, go to IDLE.
- Requester timing:
  - A requester whose req is still high after done competes again from IDLE.
  - A new grant is possible 1 cycle after RESP.
- Timeout counter: clears on every state entry and saturates; it never wraps.
- Signals latched while busy:
  - m_addr/m_wdata/m_rw are stable from LAUNCH through RESP.
  - Changes to req_addr/req_wdata/req_rw after grant are ignored.
  - Dropping req after grant does not cancel the transfer; done still pulses.
- Fairness:
  - Requests arriving while busy wait.
  - If all requesters are continuously active, each is granted once per NUM_REQ transactions.
- Invariants: grant is one-hot or zero; done is a subset of grant; m_start is never high outside LAUNCH.
- Engine protocol: m_start is held until the engine leaves idle. Because it drops on that edge, the engine cannot re-launch when it returns to IDLE.

Test Plan:
- Single write: req = 01, addr0 = 0x50, wdata0 = 0xA5, rw0 = 0 → grant = 01 next cycle; m_addr = 0x50, m_wdata = 0xA5, m_start high until m_ready falls; done[0] pulse with err_code = 00, rdata = 0x00.
- Read: req = 10, addr1 = 0x3C, rw1 = 1, engine model returns 0x5A → done[1] with rdata = 0x5A, err_code = 00; grant drops the cycle after done.
- Round-robin: req = 11 held for 4 transactions from reset → grant order 01, 10, 01, 10; ptr ends at 0.
- NACK: engine model raises m_status = 0x04 then 0x10 before ready → err_code = 01 with done; the next transaction is unaffected and returns err_code = 00.
- Hang:
  - Engine never drops m_ready with TIMEOUT = 16 → after 16 cycles in LAUNCH, m_abort high for 4 cycles, then done with err_code = 10.
  - Ready stuck low with TIMEOUT = 16 → err_code = 11.
- rst asserted mid-WAIT_DONE → grant, m_start and done are 0 immediately with no done pulse; after release, a pending req is re-granted normally.

Source files
------------

// File: rtl/i2c_txn_arbiter.sv
// -----------------------------------------------------------------------------
// i2c_txn_arbiter
//
// Shares one I2C master engine between NUM_REQ requesters. A round-robin
// arbiter picks a winner while the engine is idle. The winner's address, write
// byte and direction are latched and held on the engine inputs. The block then
// drives the engine start bit, follows the ready/status handshake, and returns
// read data, a one-cycle done pulse and an error code to the winner. A transfer
// that hangs in launch or in completion is aborted by pulsing an engine reset.
//
// Ports
//   clk        system clock
//   rst        asynchronous active-high reset
//   req        per-requester request level
//   req_addr   packed 7-bit slave addresses, requester i at [7i+6:7i]
//   req_wdata  packed write bytes, requester i at [8i+7:8i]
//   req_rw     per-requester direction (1 = read)
//   grant      one-hot current owner of the engine
//   done       one-cycle completion pulse to the owner
//   rdata      read byte, valid with done
//   err_code   valid with done: 00 ok, 01 NACK, 10 launch timeout,
//              11 completion timeout
//   m_addr     engine slave address
//   m_wdata    engine write byte
//   m_rw       engine direction
//   m_start    engine start bit (control_reg[1])
//   m_ready    engine idle / out of reset
//   m_rdata    engine read byte
//   m_status   engine status, bit 2 = address NACK
//   m_abort    engine reset request after a timeout
// -----------------------------------------------------------------------------
module i2c_txn_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int TIMEOUT   = 1024,
  parameter int ABORT_LEN = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [7*NUM_REQ-1:0]   req_addr,
  input  logic [8*NUM_REQ-1:0]   req_wdata,
  input  logic [NUM_REQ-1:0]     req_rw,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     done,
  output logic [7:0]             rdata,
  output logic [1:0]             err_code,
  output logic [6:0]             m_addr,
  output logic [7:0]             m_wdata,
  output logic                   m_rw,
  output logic                   m_start,
  input  logic                   m_ready,
  input  logic [7:0]             m_rdata,
  input  logic [7:0]             m_status,
  output logic                   m_abort
);

  localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_MAX = (TIMEOUT > ABORT_LEN) ? TIMEOUT : ABORT_LEN;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] AB_LAST = CNT_W'(ABORT_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};
  localparam logic [PTR_W-1:0] PTR_TOP = PTR_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_ABORT     = 3'd3,
    ST_RESP      = 3'd4
  } state_t;

  // Round-robin search starting at p. Scanning from the farthest offset back
  // to offset 0 lets the nearest requester overwrite the result, so the loop
  // needs no early exit. Result is {found, index}.
  function automatic logic [PTR_W:0] pick_winner(input logic [NUM_REQ-1:0] r,
                                                 input logic [PTR_W-1:0]   p);
    logic             found_v;
    logic [PTR_W-1:0] idx_v;
    logic [PTR_W-1:0] cand_v;
    int               sum_v;
    found_v = 1'b0;
    idx_v   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      sum_v   = int'(p) + i;
      sum_v   = (sum_v >= NUM_REQ) ? (sum_v - NUM_REQ) : sum_v;
      cand_v  = PTR_W'(sum_v);
      found_v = r[cand_v] ? 1'b1 : found_v;
      idx_v   = r[cand_v] ? cand_v : idx_v;
    end
    return {found_v, idx_v};
  endfunction

  state_t               state_r, state_s;
  logic [PTR_W-1:0]     ptr_r, ptr_s;
  logic [PTR_W-1:0]     owner_r, owner_s;
  logic [CNT_W-1:0]     cnt_r, cnt_s;
  logic                 nack_r, nack_s;
  logic [NUM_REQ-1:0]   grant_r, grant_s;
  logic [NUM_REQ-1:0]   done_r, done_s;
  logic [7:0]           rdata_r, rdata_s;
  logic [1:0]           err_r, err_s;
  logic [6:0]           m_addr_r, m_addr_s;
  logic [7:0]           m_wdata_r, m_wdata_s;
  logic                 m_rw_r, m_rw_s;
  logic                 m_start_r, m_start_s;
  logic                 m_abort_r, m_abort_s;

  logic [PTR_W:0]       pick_s;
  logic                 win_found_s;
  logic [PTR_W-1:0]     win_idx_s;
  logic                 nack_now_s;

  // Arbitration result and the NACK flag including the current cycle.
  always_comb begin
    pick_s      = pick_winner(req, ptr_r);
    win_found_s = pick_s[PTR_W];
    win_idx_s   = pick_s[PTR_W-1:0];
    nack_now_s  = nack_r | m_status[2];
  end

  // Next-state and next-output logic; every output is registered.
  always_comb begin
    state_s   = state_r;
    ptr_s     = ptr_r;
    owner_s   = owner_r;
    cnt_s     = (cnt_r == CNT_SAT) ? cnt_r : (cnt_r + CNT_W'(1));
    nack_s    = nack_r;
    grant_s   = grant_r;
    done_s    = done_r;
    rdata_s   = rdata_r;
    err_s     = err_r;
    m_addr_s  = m_addr_r;
    m_wdata_s = m_wdata_r;
    m_rw_s    = m_rw_r;
    m_start_s = m_start_r;
    m_abort_s = m_abort_r;

    case (state_r)
      ST_IDLE: begin
        if (win_found_s && m_ready) begin
          owner_s   = win_idx_s;
          grant_s   = ONE_HOT0 << win_idx_s;
          m_addr_s  = req_addr[7*int'(win_idx_s) +: 7];
          m_wdata_s = req_wdata[8*int'(win_idx_s) +: 8];
          m_rw_s    = req_rw[win_idx_s];
          m_start_s = 1'b1;
          rdata_s   = 8'h00;
          err_s     = 2'b00;
          cnt_s     = '0;
          state_s   = ST_LAUNCH;
        end else begin
          state_s   = ST_IDLE;
        end
      end

      ST_LAUNCH: begin
        // The engine leaving idle is the acknowledgement of start; dropping
        // start on this edge prevents a second launch when it returns to idle.
        if (!m_ready) begin
          m_start_s = 1'b0;
          cnt_s     = '0;
          nack_s    = 1'b0;
          state_s   = ST_WAIT_DONE;
        end else if (cnt_r == TO_LAST) begin
          m_start_s = 1'b0;
          m_abort_s = 1'b1;
          err_s     = 2'b10;
          rdata_s   = 8'h00;
          cnt_s     = '0;
          state_s   = ST_ABORT;
        end else begin
          state_s   = ST_LAUNCH;
        end
      end

      ST_WAIT_DONE: begin
        nack_s = nack_now_s;
        if (m_ready) begin
          rdata_s = m_rw_r ? m_rdata : 8'h00;
          err_s   = nack_now_s ? 2'b01 : 2'b00;
          done_s  = grant_r;
          cnt_s   = '0;
          state_s = ST_RESP;
        end else if (cnt_r == TO_LAST) begin
          m_abort_s = 1'b1;
          err_s     = 2'b11;
          rdata_s   = 8'h00;
          cnt_s     = '0;
          state_s   = ST_ABORT;
        end else begin
          state_s   = ST_WAIT_DONE;
        end
      end

      ST_ABORT: begin
        if (cnt_r == AB_LAST) begin
          m_abort_s = 1'b0;
          done_s    = grant_r;
          cnt_s     = '0;
          state_s   = ST_RESP;
        end else begin
          state_s   = ST_ABORT;
        end
      end

      ST_RESP: begin
        done_s  = '0;
        grant_s = '0;
        ptr_s   = (owner_r == PTR_TOP) ? '0 : (owner_r + PTR_W'(1));
        cnt_s   = '0;
        state_s = ST_IDLE;
      end

      default: begin
        state_s   = ST_IDLE;
        grant_s   = '0;
        done_s    = '0;
        m_start_s = 1'b0;
        m_abort_s = 1'b0;
        cnt_s     = '0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      ptr_r     <= '0;
      owner_r   <= '0;
      cnt_r     <= '0;
      nack_r    <= 1'b0;
      grant_r   <= '0;
      done_r    <= '0;
      rdata_r   <= 8'h00;
      err_r     <= 2'b00;
      m_addr_r  <= 7'h00;
      m_wdata_r <= 8'h00;
      m_rw_r    <= 1'b0;
      m_start_r <= 1'b0;
      m_abort_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      ptr_r     <= ptr_s;
      owner_r   <= owner_s;
      cnt_r     <= cnt_s;
      nack_r    <= nack_s;
      grant_r   <= grant_s;
      done_r    <= done_s;
      rdata_r   <= rdata_s;
      err_r     <= err_s;
      m_addr_r  <= m_addr_s;
      m_wdata_r <= m_wdata_s;
      m_rw_r    <= m_rw_s;
      m_start_r <= m_start_s;
      m_abort_r <= m_abort_s;
    end
  end

  assign grant    = grant_r;
  assign done     = done_r;
  assign rdata    = rdata_r;
  assign err_code = err_r;
  assign m_addr   = m_addr_r;
  assign m_wdata  = m_wdata_r;
  assign m_rw     = m_rw_r;
  assign m_start  = m_start_r;
  assign m_abort  = m_abort_r;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for i2c_txn_arbiter (NUM_REQ=2, TIMEOUT=16,
// ABORT_LEN=4). The engine handshake is driven step by step from one initial
// block. Inputs change 1 time unit after the rising edge and outputs are
// sampled at the same point.
// -----------------------------------------------------------------------------
module tb_i2c_txn_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [13:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_rw;
  logic [1:0]  grant;
  logic [1:0]  done;
  logic [7:0]  rdata;
  logic [1:0]  err_code;
  logic [6:0]  m_addr;
  logic [7:0]  m_wdata;
  logic        m_rw;
  logic        m_start;
  logic        m_ready;
  logic [7:0]  m_rdata;
  logic [7:0]  m_status;
  logic        m_abort;

  int n_total = 0;
  int n_bad   = 0;

  i2c_txn_arbiter #(.NUM_REQ(2), .TIMEOUT(16), .ABORT_LEN(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_rw    (req_rw),
    .grant     (grant),
    .done      (done),
    .rdata     (rdata),
    .err_code  (err_code),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_rw      (m_rw),
    .m_start   (m_start),
    .m_ready   (m_ready),
    .m_rdata   (m_rdata),
    .m_status  (m_status),
    .m_abort   (m_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [1:0] rr_exp [0:4];

  initial begin
    rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01;
    rr_exp[3] = 2'b10; rr_exp[4] = 2'b01;

    rst = 1'b1; req = 2'b00; req_addr = 14'h0000; req_wdata = 16'h0000;
    req_rw = 2'b00; m_ready = 1'b1; m_rdata = 8'h00; m_status = 8'h00;
    #12;
    chk("rst_grant", grant, 2'b00);
    chk("rst_done", done, 2'b00);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_err", err_code, 2'b00);
    chk("rst_maddr", m_addr, 7'h00);
    chk("rst_mstart", m_start, 1'b0);
    chk("rst_mabort", m_abort, 1'b0);
    tick();
    rst = 1'b0;
    tick();

    // ---- single write from requester 0 ----
    req_addr[6:0] = 7'h50; req_wdata[7:0] = 8'hA5; req_rw[0] = 1'b0; req = 2'b01;
    tick();
    chk("wr_grant", grant, 2'b01);
    chk("wr_maddr", m_addr, 7'h50);
    chk("wr_mwdata", m_wdata, 8'hA5);
    chk("wr_mrw", m_rw, 1'b0);
    chk("wr_mstart", m_start, 1'b1);
    m_ready = 1'b0; req = 2'b00;
    tick();
    chk("wr_mstart_drop", m_start, 1'b0);
    tick();
    chk("wr_grant_held", grant, 2'b01);
    chk("wr_no_done", done, 2'b00);
    m_ready = 1'b1; m_rdata = 8'hEE;
    tick();
    chk("wr_done", done, 2'b01);
    chk("wr_err", err_code, 2'b00);
    chk("wr_rdata", rdata, 8'h00);
    tick();
    chk("wr_done_clr", done, 2'b00);
    chk("wr_grant_clr", grant, 2'b00);

    // ---- read from requester 1; later input changes must be ignored ----
    req_addr[13:7] = 7'h3C; req_rw[1] = 1'b1; req = 2'b10;
    tick();
    chk("rd_grant", grant, 2'b10);
    chk("rd_maddr", m_addr, 7'h3C);
    chk("rd_mrw", m_rw, 1'b1);
    req_addr[13:7] = 7'h11; req_rw[1] = 1'b0; m_ready = 1'b0;
    tick();
    chk("rd_mstart_drop", m_start, 1'b0);
    m_ready = 1'b1; m_rdata = 8'h5A;
    tick();
    chk("rd_done", done, 2'b10);
    chk("rd_rdata", rdata, 8'h5A);
    chk("rd_err", err_code, 2'b00);
    chk("rd_maddr_stable", m_addr, 7'h3C);
    chk("rd_mrw_stable", m_rw, 1'b1);
    req = 2'b00;
    tick();
    chk("rd_grant_clr", grant, 2'b00);

    // ---- round robin from reset with both requesting ----
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_addr = {7'h20, 7'h10}; req_rw = 2'b10; req = 2'b11;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_grant", grant, rr_exp[k]);
      chk("rr_maddr", m_addr, (rr_exp[k] == 2'b01) ? 7'h10 : 7'h20);
      m_ready = 1'b0;
      tick();
      m_ready = 1'b1; m_rdata = 8'hC3;
      tick();
      chk("rr_done", done, rr_exp[k]);
      chk("rr_rdata", rdata, (rr_exp[k] == 2'b10) ? 8'hC3 : 8'h00);
      tick();
      chk("rr_idle_grant", grant, 2'b00);
    end
    req = 2'b00;

    // ---- NACK reported, next transfer clean ----
    req_addr[6:0] = 7'h48; req_rw[0] = 1'b1; req = 2'b01;
    tick();
    chk("nk_grant", grant, 2'b01);
    m_ready = 1'b0;
    tick();
    m_status = 8'h04;
    tick();
    m_status = 8'h10;
    tick();
    m_status = 8'h00; m_ready = 1'b1; m_rdata = 8'h33;
    tick();
    chk("nk_done", done, 2'b01);
    chk("nk_err", err_code, 2'b01);
    chk("nk_rdata", rdata, 8'h33);
    tick();
    tick();
    chk("nk2_grant", grant, 2'b01);
    m_ready = 1'b0;
    tick();
    tick();
    m_ready = 1'b1; m_rdata = 8'h44;
    tick();
    chk("nk2_done", done, 2'b01);
    chk("nk2_err", err_code, 2'b00);
    chk("nk2_rdata", rdata, 8'h44);
    req = 2'b00;
    tick();

    // ---- launch hang: engine never leaves idle ----
    req_rw[0] = 1'b0; req = 2'b01;
    tick();
    chk("lh_grant", grant, 2'b01);
    repeat (15) tick();
    chk("lh_mstart_15", m_start, 1'b1);
    chk("lh_mabort_15", m_abort, 1'b0);
    tick();
    chk("lh_mabort_on", m_abort, 1'b1);
    chk("lh_mstart_off", m_start, 1'b0);
    chk("lh_err_early", err_code, 2'b10);
    repeat (3) tick();
    chk("lh_mabort_hold", m_abort, 1'b1);
    chk("lh_no_done", done, 2'b00);
    tick();
    chk("lh_mabort_off", m_abort, 1'b0);
    chk("lh_done", done, 2'b01);
    chk("lh_err", err_code, 2'b10);
    req = 2'b00;
    tick();
    chk("lh_grant_clr", grant, 2'b00);

    // ---- completion hang: ready stuck low ----
    req = 2'b01;
    tick();
    chk("ch_grant", grant, 2'b01);
    m_ready = 1'b0;
    tick();
    repeat (15) tick();
    chk("ch_mabort_15", m_abort, 1'b0);
    tick();
    chk("ch_mabort_on", m_abort, 1'b1);
    chk("ch_err_early", err_code, 2'b11);
    repeat (4) tick();
    chk("ch_done", done, 2'b01);
    chk("ch_err", err_code, 2'b11);
    chk("ch_mabort_off", m_abort, 1'b0);
    m_ready = 1'b1; req = 2'b00;
    tick();
    chk("ch_grant_clr", grant, 2'b00);

    // ---- reset during WAIT_DONE ----
    req_addr[13:7] = 7'h22; req_rw[1] = 1'b0; req = 2'b10;
    tick();
    chk("rs_grant", grant, 2'b10);
    m_ready = 1'b0;
    tick();
    tick();
    #3;
    rst = 1'b1;
    #1;
    chk("rs_grant_async", grant, 2'b00);
    chk("rs_mstart_async", m_start, 1'b0);
    chk("rs_done_async", done, 2'b00);
    tick();
    chk("rs_done_held", done, 2'b00);
    m_ready = 1'b1;
    rst = 1'b0;
    tick();
    chk("rs_regrant", grant, 2'b10);
    chk("rs_maddr", m_addr, 7'h22);
    m_ready = 1'b0;
    tick();
    m_ready = 1'b1; m_rdata = 8'h00;
    tick();
    chk("rs_done", done, 2'b10);
    chk("rs_err", err_code, 2'b00);
    req = 2'b00;
    tick();
    chk("rs_grant_clr", grant, 2'b00);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
